// File: rtl/dp_ram_be.sv
// Simple dual-port synchronous RAM with byte-enabled writes, registered reads,
// selectable read-during-write result and a hardware zero sweep after reset or clr.
module dp_ram_be #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid
);

    localparam int NBE   = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SP_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] SP_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam bit WRITE_FIRST = (RDW_MODE == 32'sd1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   sp_r;
    logic                busy_r;
    logic [DATA_W-1:0]   rd_data_r;
    logic                rd_valid_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    logic                wr_ok_s;
    logic                rd_ok_s;
    logic                collide_s;
    logic [DATA_W-1:0]   wr_merged_s;
    logic [DATA_W-1:0]   rd_word_s;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NBE-1:0]    be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NBE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Request qualification, write merge and read-word selection.
    always_comb begin
        wr_ok_s     = 1'b0;
        rd_ok_s     = 1'b0;
        if (state_r == ST_IDLE) begin
            wr_ok_s = wr_en;
            rd_ok_s = rd_en;
        end else begin
            wr_ok_s = 1'b0;
            rd_ok_s = 1'b0;
        end
        collide_s   = wr_ok_s && rd_ok_s && (wr_addr == rd_addr);
        wr_merged_s = be_merge(mem_r[wr_addr], wr_data, wr_be);
        // Read-first falls out of the array update being non-blocking.
        if (WRITE_FIRST && collide_s) begin
            rd_word_s = wr_merged_s;
        end else begin
            rd_word_s = mem_r[rd_addr];
        end
    end

    // Sweep FSM and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_CLEAR;
            sp_r       <= {ADDR_W{1'b0}};
            busy_r     <= 1'b1;
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    sp_r <= sp_r + SP_ONE;
                    if (sp_r == SP_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        state_r <= ST_CLEAR;
                        sp_r    <= {ADDR_W{1'b0}};
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    sp_r    <= {ADDR_W{1'b0}};
                    busy_r  <= 1'b1;
                end
            endcase
            rd_valid_r <= rd_ok_s;
            if (rd_ok_s) begin
                rd_data_r <= rd_word_s;
            end
        end
    end

    // Storage array: sweep zeroes one word per edge, otherwise accepted writes land.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[sp_r] <= {DATA_W{1'b0}};
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_merged_s;
        end
    end

    assign busy     = busy_r;
    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_dp_ram_be.sv
// Scoreboard bench for dp_ram_be: read-first and write-first 16x16 instances
// share one stimulus stream, plus a 32-bit x 64-word instance on its own stream.
module tb_dp_ram_be;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, wr_en, rd_en;
    logic [3:0]  wa, ra;
    logic [1:0]  be;
    logic [15:0] wd;
    logic        busy_a, busy_b, rv_a, rv_b;
    logic [15:0] rd_a, rd_b;

    logic        rst_c, clr_c, we_c, re_c;
    logic [5:0]  wa_c, ra_c;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic        busy_c, rv_c;
    logic [31:0] rd_c;

    dp_ram_be #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
        .wr_en(wr_en), .wr_addr(wa), .wr_be(be), .wr_data(wd),
        .rd_en(rd_en), .rd_addr(ra), .rd_data(rd_a), .rd_valid(rv_a));

    dp_ram_be #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_b),
        .wr_en(wr_en), .wr_addr(wa), .wr_be(be), .wr_data(wd),
        .rd_en(rd_en), .rd_addr(ra), .rd_data(rd_b), .rd_valid(rv_b));

    dp_ram_be #(.DATA_W(32), .ADDR_W(6), .RDW_MODE(0)) dut_c (
        .clk(clk), .rst(rst_c), .clr(clr_c), .busy(busy_c),
        .wr_en(we_c), .wr_addr(wa_c), .wr_be(be_c), .wr_data(wd_c),
        .rd_en(re_c), .rd_addr(ra_c), .rd_data(rd_c), .rd_valid(rv_c));

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mdl16 [16];
    logic [31:0] mdl32 [64];
    int          cnt16 = 0;
    int          cnt32 = 0;
    logic [15:0] qa[$], qb[$];
    logic [31:0] qc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] b);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // One clock of 16-bit stimulus; the model decides acceptance and expected reads.
    task automatic op16(input logic we, input logic [3:0] wa_i, input logic [1:0] be_i,
                        input logic [15:0] wd_i, input logic re, input logic [3:0] ra_i,
                        input logic c);
        logic [15:0] m, merged, ea, eb;
        logic acc;
        wr_en = we; wa = wa_i; be = be_i; wd = wd_i; rd_en = re; ra = ra_i; clr = c;
        acc    = (cnt16 == 0);
        m      = 16'(be_mask({2'b00, be_i}));
        merged = (mdl16[wa_i] & ~m) | (wd_i & m);
        ea     = mdl16[ra_i];
        eb     = (we && wa_i == ra_i) ? merged : ea;
        if (acc) begin
            if (we) mdl16[wa_i] = merged;
            if (c) begin
                cnt16 = 16;
                for (int i = 0; i < 16; i++) mdl16[i] = 16'h0;
            end
        end else begin
            cnt16--;
        end
        @(posedge clk);
        if (acc && re) begin
            qa.push_back(ea);
            qb.push_back(eb);
        end
        #1;
        chk("busy_a", 32'(busy_a), 32'(cnt16 != 0));
        chk("busy_b", 32'(busy_b), 32'(cnt16 != 0));
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    endtask

    task automatic op32(input logic we, input logic [5:0] wa_i, input logic [3:0] be_i,
                        input logic [31:0] wd_i, input logic re, input logic [5:0] ra_i,
                        input logic c);
        logic [31:0] m, merged, ec;
        logic acc;
        we_c = we; wa_c = wa_i; be_c = be_i; wd_c = wd_i; re_c = re; ra_c = ra_i; clr_c = c;
        acc    = (cnt32 == 0);
        m      = be_mask(be_i);
        merged = (mdl32[wa_i] & ~m) | (wd_i & m);
        ec     = mdl32[ra_i];
        if (acc) begin
            if (we) mdl32[wa_i] = merged;
            if (c) begin
                cnt32 = 64;
                for (int i = 0; i < 64; i++) mdl32[i] = 32'h0;
            end
        end else begin
            cnt32--;
        end
        @(posedge clk);
        if (acc && re) qc.push_back(ec);
        #1;
        chk("busy_c", 32'(busy_c), 32'(cnt32 != 0));
        we_c = 1'b0; re_c = 1'b0; clr_c = 1'b0;
    endtask

    task automatic reset16();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_rdata_a", 32'(rd_a), 32'h0);
        chk("rst_rdata_b", 32'(rd_b), 32'h0);
        chk("rst_valid_a", 32'(rv_a), 32'h0);
        chk("rst_busy_a", 32'(busy_a), 32'h1);
        qa.delete();
        qb.delete();
        cnt16 = 16;
        for (int i = 0; i < 16; i++) mdl16[i] = 16'h0;
        #3;
        rst = 1'b0;
    endtask

    task automatic reset32();
        @(posedge clk);
        #3;
        rst_c = 1'b1;
        #1;
        chk("rst_rdata_c", rd_c, 32'h0);
        chk("rst_busy_c", 32'(busy_c), 32'h1);
        qc.delete();
        cnt32 = 64;
        for (int i = 0; i < 64; i++) mdl32[i] = 32'h0;
        #3;
        rst_c = 1'b0;
    endtask

    // Scoreboard pop: rd_valid must appear exactly when a read was accepted.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid_a", 32'(rv_a), 32'(qa.size() != 0));
            chk("valid_b", 32'(rv_b), 32'(qb.size() != 0));
            if (rv_a && qa.size() != 0) chk("rdata_a", 32'(rd_a), 32'(qa.pop_front()));
            if (rv_b && qb.size() != 0) chk("rdata_b", 32'(rd_b), 32'(qb.pop_front()));
        end
        if (!rst_c) begin
            chk("valid_c", 32'(rv_c), 32'(qc.size() != 0));
            if (rv_c && qc.size() != 0) chk("rdata_c", rd_c, qc.pop_front());
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wa = 4'h0; ra = 4'h0; be = 2'b00; wd = 16'h0;
        rst_c = 1'b1; clr_c = 1'b0; we_c = 1'b0; re_c = 1'b0;
        wa_c = 6'h0; ra_c = 6'h0; be_c = 4'h0; wd_c = 32'h0;

        // Power-up sweep with requests that must be dropped.
        reset16();
        for (int i = 0; i < 16; i++) op16(1'b1, 4'(i), 2'b11, 16'hDEAD, 1'b1, 4'(i), 1'b0);

        // Garbage, then reset must zero everything.
        for (int i = 0; i < 16; i++) op16(1'b1, 4'(i), 2'b11, 16'($urandom), 1'b0, 4'h0, 1'b0);
        reset16();
        for (int i = 0; i < 16; i++) op16(1'b0, 4'h0, 2'b00, 16'h0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) op16(1'b0, 4'h0, 2'b00, 16'h0, 1'b1, 4'(i), 1'b0);

        // Byte enables.
        op16(1'b1, 4'd3, 2'b11, 16'hABCD, 1'b0, 4'h0, 1'b0);
        op16(1'b1, 4'd3, 2'b01, 16'h1234, 1'b0, 4'h0, 1'b0);
        op16(1'b1, 4'd3, 2'b00, 16'hFFFF, 1'b0, 4'h0, 1'b0);
        op16(1'b0, 4'h0, 2'b00, 16'h0,    1'b1, 4'd3, 1'b0);
        op16(1'b1, 4'd3, 2'b10, 16'h5A00, 1'b0, 4'h0, 1'b0);
        op16(1'b0, 4'h0, 2'b00, 16'h0,    1'b1, 4'd3, 1'b0);

        // Same-address collisions, full and partial.
        op16(1'b1, 4'd5, 2'b11, 16'h1111, 1'b0, 4'h0, 1'b0);
        op16(1'b1, 4'd5, 2'b11, 16'h2222, 1'b1, 4'd5, 1'b0);
        op16(1'b0, 4'h0, 2'b00, 16'h0,    1'b1, 4'd5, 1'b0);
        op16(1'b1, 4'd5, 2'b10, 16'h9900, 1'b1, 4'd5, 1'b0);
        op16(1'b0, 4'h0, 2'b00, 16'h0,    1'b1, 4'd5, 1'b0);

        // Clear mid-traffic; clr during the sweep is ignored.
        for (int i = 0; i < 16; i++) op16(1'b1, 4'(i), 2'b11, 16'($urandom), 1'b0, 4'h0, 1'b0);
        op16(1'b1, 4'd7, 2'b11, 16'hBEEF, 1'b1, 4'd7, 1'b1);
        for (int i = 0; i < 16; i++) op16(1'b1, 4'(i), 2'b11, 16'h5555, 1'b1, 4'(i), 1'(i == 4));
        for (int i = 0; i < 16; i++) op16(1'b0, 4'h0, 2'b00, 16'h0, 1'b1, 4'(i), 1'b0);

        // Reset at sweep address 9 restarts a full sweep.
        for (int i = 0; i < 16; i++) op16(1'b1, 4'(i), 2'b11, 16'($urandom), 1'b0, 4'h0, 1'b0);
        reset16();
        for (int i = 0; i < 8; i++) op16(1'b0, 4'h0, 2'b00, 16'h0, 1'b0, 4'h0, 1'b0);
        reset16();
        for (int i = 0; i < 16; i++) op16(1'b1, 4'(i), 2'b11, 16'h7777, 1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 16; i++) op16(1'b0, 4'h0, 2'b00, 16'h0, 1'b1, 4'(i), 1'b0);

        // Random traffic on the narrow pair.
        repeat (300) begin
            op16(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 39) == 0));
        end

        // Wide configuration: sweep, random stream with occasional clears, final readback.
        reset32();
        repeat (600) begin
            op32(1'($urandom_range(0, 1)), 6'($urandom), 4'($urandom), $urandom,
                 1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 79) == 0));
        end
        for (int i = 0; i < 64; i++) op32(1'b0, 6'h0, 4'h0, 32'h0, 1'b1, 6'(i), 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drain", 32'(qa.size() + qb.size() + qc.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dp_ram_be.md
# dp_ram_be

Parametrised simple dual-port synchronous RAM: one write port with byte enables, one independent read port with registered 1-cycle read latency. Generalises the team's 16x16 single-port RAM in width and depth, selectable read-during-write behaviour, and a hardware clear sweep. Reset or a `clr` pulse zeroes the array. Used as a local scratch/buffer memory behind register banks and DMA-style producers.

## Interface

Parameters:
- `DATA_W`, default 16: word width in bits; must be a multiple of 8.
- `ADDR_W`, default 4: address width; DEPTH = 2**ADDR_W words.
- `RDW_MODE`, default 0: same-address read-during-write result. 0 = old data (read-first); 1 = new merged data (write-first).

Ports (derived NBE = DATA_W/8):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `clr` in 1: request a full-array zero sweep; sampled only in IDLE.
- `busy` out 1: high while sweeping; both ports are ignored while high.
- `wr_en` in 1: write request.
- `wr_addr` in ADDR_W: write address.
- `wr_be` in NBE: byte enables; bit i covers `wr_data[8i+7:8i]`.
- `wr_data` in DATA_W: write data.
- `rd_en` in 1: read request.
- `rd_addr` in ADDR_W: read address.
- `rd_data` out DATA_W: registered read data; holds its value between reads and is never high-Z.
- `rd_valid` out 1: one-cycle pulse, high in the cycle `rd_data` is updated by an accepted read.

## Operation

- **Storage**: DEPTH x DATA_W register array; no asynchronous reset on the array itself.
- **FSM states**: CLEAR, IDLE.
  - `rst` asserted: state=CLEAR, sweep pointer `sp`=0, `busy`=1, `rd_data`=0, `rd_valid`=0.
  - CLEAR: each edge writes 0 to mem[sp] and increments `sp`. On the edge that writes address DEPTH-1, go to IDLE and set `busy` to 0.
  - IDLE with `clr`=1 at an edge: go to CLEAR with `sp`=0 and `busy`=1. A write or read accepted on that same edge still completes.
  - `clr` during CLEAR is ignored; the sweep is not restarted.
  - `rst` mid-sweep restarts the sweep from address 0.
- **Write** (IDLE, `wr_en`=1): update only the bytes whose `wr_be` bit is 1. With `wr_be`=0 the array is unchanged.
- **Read** (IDLE, `rd_en`=1): `rd_data` <= mem[rd_addr] and `rd_valid` <= 1. Otherwise `rd_valid` <= 0 and `rd_data` holds.
- **Collision** (both enabled, `rd_addr`==`wr_addr`):
  - RDW_MODE=0: `rd_data` gets the pre-write word.
  - RDW_MODE=1: `rd_data` gets the post-write word, i.e. enabled bytes from `wr_data` and the other bytes old.
  - The array ends up with the merged word in both modes.
- **Address width**: addresses are full-width, so there are no out-of-range addresses and no wrap handling is needed.

## Timing

- **Reset values**: `busy`=1, `rd_data`=0, `rd_valid`=0.
- **Sweep duration**: exactly DEPTH edges after reset release. With DEPTH=16, `busy` falls after the 16th rising edge, and requests are accepted from the 17th edge.
- **Read latency**: 1. `rd_en` sampled at edge N gives `rd_data`/`rd_valid` valid after edge N; `rd_valid` drops after edge N+1 unless there is another read.
- **Back-to-back reads**: one read per cycle; `rd_valid` stays high continuously.
- **Write visibility**: a write at edge N is visible to a read sampled at edge N+1 with no hazard. At edge N itself the result follows the RDW_MODE rule.
- **Requests while busy**: dropped silently; `rd_valid` stays 0 and there is no queueing.

## Test plan

- **Reset sweep**: preload garbage (skip the sweep via force), then pulse `rst`. `busy`=1 for 16 cycles, then 0; a read of every address returns 0x0000 with `rd_valid` one cycle after each `rd_en`.
- **Byte enables**: write 0xABCD to address 3 with `wr_be`=2'b11, then 0x1234 with `wr_be`=2'b01. A read of address 3 gives 0xAB34.
- **Collision**: mem[5]=0x1111; same edge write 0x2222 (`be`=11) and read of address 5. RDW_MODE=0 gives `rd_data`=0x1111; RDW_MODE=1 gives 0x2222. Both modes read 0x2222 on the next read.
- **Clear mid-traffic**: fill all 16 words, then assert `clr` with a write to address 7 on the same edge. `busy` is high for 16 cycles; `wr_en` during the sweep is ignored; afterwards every address reads 0.
- **Reset mid-sweep**: assert `rst` at sweep address 9. The sweep restarts at 0 and lasts a full 16 cycles; `rd_data`=0 and `rd_valid`=0 asynchronously on `rst`.
- **Parameter sweep**: DATA_W=32, ADDR_W=6. A random write/read stream checked against a reference model, with 64-cycle clear and 4-bit byte enables correct.
